mole_autoplayer: RTL and testbench
==================================

Name: mole_autoplayer

Overview:
- Automated "player" for the whac-a-mole game: the switch-side counterpart of the mole generator and hit logic.
- Watches mole_positions and, after a human-like reaction delay, toggles the switch for each raised mole, one at a time.
- Drives the same switch vector the hit logic reads. Used for attract/demo mode and as a self-playing stimulus source for system-level verification.
- A whack is defined as inverting exactly one bit of switches.

Parameters:
- NUM_HOLES, 18, width of mole_positions/switches
- CLK_PER_MS, 50000, clk cycles per millisecond tick
- REACTION_MS, 150, delay from a mole being seen to the first whack
- STEP_MS, 50, gap between successive whacks within one burst
- MISS_PERIOD, 8, every MISS_PERIOD-th whack is a deliberate miss (only with AUTOPLAYER_MISS_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  connect to game_in_progress; low forces IDLE
- mole_positions  in  NUM_HOLES  1 = mole raised in that hole
- switches  out  NUM_HOLES  registered virtual switch vector
- whack_pulse  out  1  one-cycle pulse on the cycle switches changes
- busy  out  1  high in any state other than IDLE
- whack_count  out  16  total whacks issued, saturates at 16'hFFFF

Behaviour:
- Reset (async, active-high): switches = 0, whack_pulse = 0, busy = 0, whack_count = 0, whacked mask = 0, ms prescaler = 0, state = IDLE.
- whacked mask, updated every cycle: whacked <= (whacked & mole_positions) | set_bit.
  - A mole going down clears its bit.
  - set_bit is the target's one-hot in WHACK on a real hit; otherwise 0.
- pending = mole_positions & ~whacked (combinational).
- ms tick: prescaler counts 0..CLK_PER_MS-1 and pulses on the wrap. It restarts at 0 on entry to WAIT_REACT and to SETTLE.
- States:
  - IDLE: enable && pending != 0 -> WAIT_REACT.
  - WAIT_REACT: counts REACTION_MS ms ticks. If pending == 0 before expiry -> IDLE with no toggle. On the REACTION_MS-th tick -> SELECT.
  - SELECT (1 cycle): target = lowest set index of pending. If pending == 0 -> IDLE.
  - WHACK (1 cycle): switches[target] inverted; whack_pulse = 1; whack_count++ (saturating); target's whacked bit set if it was a real hit. -> SETTLE.
  - SETTLE: counts STEP_MS ms ticks, then -> SELECT if pending != 0, else IDLE.
- Latency: pending first nonzero at cycle N -> IDLE exits at N+1 -> switches/whack_pulse update at N + REACTION_MS*CLK_PER_MS + 3.
  - Successive whacks in a burst are STEP_MS*CLK_PER_MS + 2 cycles apart.
- Enable low in any state:
  - Next cycle state = IDLE, prescaler and ms counters cleared, whacked cleared.
  - switches holds its value; it is never reset by enable.
  - whack_count holds.
- mole_positions changing mid-burst: SELECT always re-evaluates live pending. Moles that went down are skipped; new moles are picked up in the same burst.
- Moles never seen raised are never toggled. Each raised mole is whacked at most once per raise.

Optional Feature:
- AUTOPLAYER_MISS_EN defined:
  - In SELECT, if whack_count mod MISS_PERIOD == MISS_PERIOD-1, target becomes the first hole after the chosen index (wrapping modulo NUM_HOLES) whose mole_positions bit is 0.
  - That whack is a miss and sets no whacked bit.
  - If every hole has a mole, the normal target is used and counts as a hit.
- Undefined: no deliberate misses; MISS_PERIOD is unused.

Test Plan (NUM_HOLES=8, CLK_PER_MS=4, REACTION_MS=2, STEP_MS=1, MISS_PERIOD=2):
- Reset pulse mid-run -> switches=8'h00, busy=0, whack_count=0, state IDLE immediately (async).
- enable=1, mole_positions 8'h00->8'h04 at cycle N -> switches=8'h04 and whack_pulse=1 exactly at N+11; whack_count=1; busy falls after SETTLE.
- mole_positions=8'h22 -> bit1 toggled at N+11, bit5 toggled 6 cycles later; whack_count=2; no third whack.
- mole_positions=8'h10, dropped to 8'h00 at N+5 (inside WAIT_REACT) -> no whack_pulse, switches unchanged, back to IDLE.
- enable dropped during SETTLE with switches=8'h04 -> IDLE next cycle, switches stays 8'h04; re-enable with the same mole raised -> it is whacked again (whacked was cleared), switches=8'h00.
- With AUTOPLAYER_MISS_EN, whack_count=1, mole_positions=8'h08 -> toggle lands on bit4 (switches bit4 flips, bit3 untouched). The next whack hits bit3 STEP later.

Source files
------------

// File: rtl/mole_autoplayer.sv
// Self-playing whac-a-mole switch driver: reacts to raised moles and
// toggles one switch per whack. Optional feature macro: AUTOPLAYER_MISS_EN.
module mole_autoplayer #(
   parameter int NUM_HOLES   = 18,
   parameter int CLK_PER_MS  = 50000,
   parameter int REACTION_MS = 150,
   parameter int STEP_MS     = 50,
   parameter int MISS_PERIOD = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [NUM_HOLES-1:0] mole_positions,
   output logic [NUM_HOLES-1:0] switches,
   output logic                 whack_pulse,
   output logic                 busy,
   output logic [15:0]          whack_count
);

   localparam int IW     = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
   localparam int PW     = $clog2(CLK_PER_MS + 1);
   localparam int MS_MAX = (REACTION_MS > STEP_MS) ? REACTION_MS : STEP_MS;
   localparam int MW     = $clog2(MS_MAX + 1);

   localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_PER_MS - 1);
   localparam logic [MW-1:0] REACT_LAST = MW'(REACTION_MS - 1);
   localparam logic [MW-1:0] STEP_LAST  = MW'(STEP_MS - 1);

`ifdef AUTOPLAYER_MISS_EN
   localparam bit MISS_EN = 1'b1;
`else
   localparam bit MISS_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      WAIT_REACT,
      SELECT,
      WHACK,
      SETTLE
   } state_t;

   state_t               state;
   logic [PW-1:0]        presc;
   logic [MW-1:0]        ms_cnt;
   logic [NUM_HOLES-1:0] whacked;
   logic [NUM_HOLES-1:0] target_oh;
   logic                 target_hit;

   logic [NUM_HOLES-1:0] pending;
   logic [NUM_HOLES-1:0] set_bit;
   logic [NUM_HOLES-1:0] sel_oh;
   logic                 sel_hit;
   logic [IW-1:0]        pick_idx;
   logic [IW-1:0]        alt_idx;
   logic [IW-1:0]        probe;
   logic                 alt_ok;
   logic                 miss_slot;
   logic                 tick;

   assign pending   = mole_positions & ~whacked;
   assign tick      = (presc == PRE_LAST);
   assign miss_slot = MISS_EN &&
                      ((int'(whack_count) % MISS_PERIOD) == (MISS_PERIOD - 1));
   assign set_bit   = (state == WHACK && target_hit && enable) ? target_oh : '0;

   // Lowest-index mole that is up and not yet whacked this raise
   always_comb begin
      pick_idx = '0;
      for (int i = NUM_HOLES - 1; i >= 0; i--) begin
         if (pending[i]) pick_idx = IW'(i);
      end
   end

   // First empty hole after the chosen one, wrapping around
   always_comb begin
      alt_idx = pick_idx;
      alt_ok  = 1'b0;
      probe   = '0;
      for (int k = NUM_HOLES - 1; k >= 1; k--) begin
         probe = IW'((int'(pick_idx) + k) % NUM_HOLES);
         if (!mole_positions[probe]) begin
            alt_idx = probe;
            alt_ok  = 1'b1;
         end
      end
   end

   // Final target: deliberate miss only when an empty hole exists
   always_comb begin
      sel_oh  = NUM_HOLES'(1) << pick_idx;
      sel_hit = 1'b1;
      if (miss_slot && alt_ok) begin
         sel_oh  = NUM_HOLES'(1) << alt_idx;
         sel_hit = 1'b0;
      end
   end

   // Whacked mask: bits drop with their mole, set on a real hit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         whacked <= '0;
      end else if (!enable) begin
         whacked <= '0;
      end else begin
         whacked <= (whacked & mole_positions) | set_bit;
      end
   end

   // Sequencer: reaction delay, pick one target, whack, settle gap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         presc       <= '0;
         ms_cnt      <= '0;
         target_oh   <= '0;
         target_hit  <= 1'b0;
         switches    <= '0;
         whack_pulse <= 1'b0;
         busy        <= 1'b0;
         whack_count <= '0;
      end else begin
         whack_pulse <= 1'b0;
         if (!enable) begin
            state  <= IDLE;
            busy   <= 1'b0;
            presc  <= '0;
            ms_cnt <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (|pending) begin
                     state  <= WAIT_REACT;
                     busy   <= 1'b1;
                     presc  <= '0;
                     ms_cnt <= '0;
                  end
               end
               WAIT_REACT: begin
                  if (!(|pending)) begin
                     state  <= IDLE;
                     busy   <= 1'b0;
                     presc  <= '0;
                     ms_cnt <= '0;
                  end else if (tick) begin
                     presc <= '0;
                     if (ms_cnt == REACT_LAST) begin
                        state  <= SELECT;
                        ms_cnt <= '0;
                     end else begin
                        ms_cnt <= ms_cnt + MW'(1);
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               SELECT: begin
                  if (!(|pending)) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     target_oh  <= sel_oh;
                     target_hit <= sel_hit;
                     state      <= WHACK;
                  end
               end
               WHACK: begin
                  switches    <= switches ^ target_oh;
                  whack_pulse <= 1'b1;
                  if (whack_count != 16'hFFFF)
                     whack_count <= whack_count + 16'd1;
                  presc  <= '0;
                  ms_cnt <= '0;
                  state  <= SETTLE;
               end
               SETTLE: begin
                  if (tick) begin
                     presc <= '0;
                     if (ms_cnt == STEP_LAST) begin
                        ms_cnt <= '0;
                        if (|pending) begin
                           state <= SELECT;
                        end else begin
                           state <= IDLE;
                           busy  <= 1'b0;
                        end
                     end else begin
                        ms_cnt <= ms_cnt + MW'(1);
                     end
                  end else begin
                     presc <= presc + PW'(1);
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mole_autoplayer.sv
// Directed scoreboard bench for mole_autoplayer (8 holes, 4 clk/ms,
// 150->2 ms reaction, 1 ms step). AUTOPLAYER_MISS_EN selects the miss scenario.
module tb_mole_autoplayer;

   localparam int NH = 8;

   typedef struct {
      int            cyc;
      logic [NH-1:0] sw;
      logic [15:0]   cnt;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          enable;
   logic [NH-1:0] mole_positions;
   logic [NH-1:0] switches;
   logic          whack_pulse;
   logic          busy;
   logic [15:0]   whack_count;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int n;
   int k;

   exp_t          sb[$];
   logic [NH-1:0] exp_sw;
   logic [15:0]   exp_cnt;

   mole_autoplayer #(
      .NUM_HOLES  (NH),
      .CLK_PER_MS (4),
      .REACTION_MS(2),
      .STEP_MS    (1),
      .MISS_PERIOD(2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .mole_positions(mole_positions),
      .switches      (switches),
      .whack_pulse   (whack_pulse),
      .busy          (busy),
      .whack_count   (whack_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step(input int num);
      repeat (num) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %0h required %0h", tag, got, want);
      end
   endtask

   task automatic push_whack(input logic [NH-1:0] mask, input int at);
      exp_sw = exp_sw ^ mask;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      sb.push_back('{cyc: at, sw: exp_sw, cnt: exp_cnt});
   endtask

   // Scoreboard: every whack pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst && whack_pulse) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_whack: pulse at cycle %0d sw=%0h, required none",
                   cyc, switches);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            assert (cyc === e.cyc) else begin
               fails++;
               $error("FAIL whack_cycle: got %0d required %0d", cyc, e.cyc);
            end
            tests++;
            assert (switches === e.sw) else begin
               fails++;
               $error("FAIL whack_switches: got %0h required %0h", switches, e.sw);
            end
            tests++;
            assert (whack_count === e.cnt) else begin
               fails++;
               $error("FAIL whack_count: got %0d required %0d", whack_count, e.cnt);
            end
         end
      end
   end

   initial begin
      rst            = 1'b1;
      enable         = 1'b0;
      mole_positions = '0;
      exp_sw         = '0;
      exp_cnt        = '0;
      step(3);
      @(negedge clk);
      chk("rst_switches", 32'(switches), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_count", 32'(whack_count), 32'h0);
      chk("rst_pulse", 32'(whack_pulse), 32'h0);
      step(1);
      rst = 1'b0;
      step(1);
      enable = 1'b1;

`ifndef AUTOPLAYER_MISS_EN
      // single mole: whack lands 11 cycles later, busy drops after settle
      step(1);
      n = cyc;
      mole_positions = 8'h04;
      push_whack(8'h04, n + 11);
      step(14);
      @(negedge clk);
      chk("a_busy_settle", 32'(busy), 32'h1);
      step(1);
      @(negedge clk);
      chk("a_busy_fall", 32'(busy), 32'h0);
      chk("a_drained", 32'(sb.size()), 32'h0);

      // two moles in one burst, 6 cycles apart, no third whack
      step(1);
      n = cyc;
      mole_positions = 8'h22;
      push_whack(8'h02, n + 11);
      push_whack(8'h20, n + 17);
      step(24);
      @(negedge clk);
      chk("b_busy", 32'(busy), 32'h0);
      chk("b_count", 32'(whack_count), 32'd3);
      chk("b_drained", 32'(sb.size()), 32'h0);

      // mole drops inside the reaction window: no whack
      step(1);
      n = cyc;
      mole_positions = 8'h10;
      step(3);
      @(negedge clk);
      chk("c_busy_wait", 32'(busy), 32'h1);
      step(2);
      mole_positions = 8'h00;
      step(1);
      @(negedge clk);
      chk("c_busy_idle", 32'(busy), 32'h0);
      step(15);
      @(negedge clk);
      chk("c_switches", 32'(switches), 32'(exp_sw));
      chk("c_count", 32'(whack_count), 32'(exp_cnt));

      // asynchronous reset mid-run
      step(1);
      mole_positions = 8'h01;
      step(3);
      #2;
      rst = 1'b1;
      #1;
      chk("d_switches", 32'(switches), 32'h0);
      chk("d_busy", 32'(busy), 32'h0);
      chk("d_count", 32'(whack_count), 32'h0);
      chk("d_pulse", 32'(whack_pulse), 32'h0);
      mole_positions = 8'h00;
      step(2);
      rst     = 1'b0;
      exp_sw  = '0;
      exp_cnt = '0;
      step(2);

      // enable drop in settle, then re-enable re-whacks the same mole
      step(1);
      n = cyc;
      mole_positions = 8'h04;
      push_whack(8'h04, n + 11);
      step(12);
      enable = 1'b0;
      step(1);
      @(negedge clk);
      chk("e_busy_off", 32'(busy), 32'h0);
      chk("e_switches_hold", 32'(switches), 32'h04);
      chk("e_count_hold", 32'(whack_count), 32'd1);
      step(2);
      enable = 1'b1;
      k = cyc;
      push_whack(8'h04, k + 11);
      step(16);
      @(negedge clk);
      chk("e_busy_end", 32'(busy), 32'h0);
      chk("e_switches_end", 32'(switches), 32'h00);
      chk("e_drained", 32'(sb.size()), 32'h0);
`else
      // odd whack count: target slides to the next empty hole
      step(1);
      n = cyc;
      mole_positions = 8'h01;
      push_whack(8'h01, n + 11);
      step(16);
      n = cyc;
      mole_positions = 8'h08;
      push_whack(8'h10, n + 11);
      push_whack(8'h08, n + 17);
      step(24);
      @(negedge clk);
      chk("m_switches", 32'(switches), 32'h19);
      chk("m_count", 32'(whack_count), 32'd3);
      chk("m_busy", 32'(busy), 32'h0);
      chk("m_drained", 32'(sb.size()), 32'h0);
`endif

      step(2);
      chk("final_drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
